// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT datapath: coefficient width, word type and
// the moduli used to exercise the arithmetic blocks.
package ntt_pkg;

    localparam int NTT_WIDTH = 28;

    typedef logic [NTT_WIDTH-1:0] word_t;

    localparam word_t Q_12289 = 28'd12289;
    localparam word_t Q_28BIT = 28'd268369921;

endpackage : ntt_pkg

// File: rtl/mod_sub_core.sv
// Borrow-correct step of a modular subtraction: adds the modulus back
// when the raw difference went negative.
module mod_sub_core
    import ntt_pkg::*;
#(
    parameter int WIDTH = NTT_WIDTH
) (
    input  logic [WIDTH-1:0] d,
    input  logic             borrow,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    // The sum wraps modulo 2^WIDTH, which lands back in [0, q) for in-range operands.
    always_comb begin
        r = d;
        if (borrow) begin
            r = d + q;
        end else begin
            r = d;
        end
    end

endmodule : mod_sub_core

// File: rtl/mod_sub_pipe.sv
// Two-stage pipelined modular subtractor out = (x - y) mod q with
// valid/ready flow control; in_ready is combinational from out_ready.
module mod_sub_pipe
    import ntt_pkg::*;
#(
    parameter int WIDTH = NTT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] q,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    logic [WIDTH-1:0] d1_r;
    logic             b1_r;
    logic             v1_r;
    logic [WIDTH-1:0] r2_r;
    logic             v2_r;

    logic             adv1_s;
    logic             adv2_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] corr_s;

    // Stage advance: a stage moves when it is empty or its successor moves.
    always_comb begin
        adv2_s = ~v2_r | out_ready;
        adv1_s = ~v1_r | adv2_s;
    end

    // Zero-extended difference; the top bit is the borrow.
    always_comb begin
        diff_s = {1'b0, x} - {1'b0, y};
    end

    // Stage 1: raw difference and borrow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_r <= {WIDTH{1'b0}};
            b1_r <= 1'b0;
            v1_r <= 1'b0;
        end else if (adv1_s) begin
            d1_r <= diff_s[WIDTH-1:0];
            b1_r <= diff_s[WIDTH];
            v1_r <= in_valid;
        end
    end

    mod_sub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .d      (d1_r),
        .borrow (b1_r),
        .q      (q),
        .r      (corr_s)
    );

    // Stage 2: corrected result, frozen while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_r <= {WIDTH{1'b0}};
            v2_r <= 1'b0;
        end else if (adv2_s) begin
            r2_r <= corr_s;
            v2_r <= v1_r;
        end
    end

    // Output mapping; out keeps its last value when out_valid is low.
    always_comb begin
        in_ready  = adv1_s;
        out_valid = v2_r;
        out       = r2_r;
        busy      = v1_r | v2_r;
    end

endmodule : mod_sub_pipe

// File: tb/tb_mod_sub_pipe.sv
// Self-checking bench for mod_sub_pipe: directed scenarios plus a random soak
// scored against a queue-based reference of (x - y + q) % q.
module tb_mod_sub_pipe;
    import ntt_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [27:0] q;
    logic        in_valid;
    logic        in_ready;
    logic [27:0] x;
    logic [27:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [27:0] out;
    logic        busy;

    int          n_tests;
    int          n_fail;
    int          cycle;
    int          first_in;
    int          first_out;
    int          last_out;
    bit          stall_r;
    bit          last_in_xfer;
    bit          last_out_xfer;
    bit          last_in_ready;
    logic [27:0] prev_out;
    logic [27:0] exp_q[$];
    logic [27:0] got_q[$];

    mod_sub_pipe #(.WIDTH(28)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .q         (q),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [27:0] ref_sub(logic [27:0] a, logic [27:0] b, logic [27:0] m);
        longint unsigned t;
        t = (64'(a) + 64'(m) - 64'(b)) % 64'(m);
        return t[27:0];
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already driven; sample, score, then advance.
    task automatic tick();
        bit ix;
        bit ox;
        #1;
        ix = in_valid && in_ready;
        ox = out_valid && out_ready;
        check("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
        check("busy", busy, exp_q.size() != 0);
        if (stall_r) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_out", out, prev_out);
        end
        if (ox) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", ox, 1'b0);
            end else begin
                check("data", out, exp_q.pop_front());
            end
            got_q.push_back(out);
            if (first_out < 0) first_out = cycle;
            last_out = cycle;
        end
        if (ix) begin
            exp_q.push_back(ref_sub(x, y, q));
            if (first_in < 0) first_in = cycle;
        end
        last_in_xfer  = ix;
        last_out_xfer = ox;
        last_in_ready = in_ready;
        stall_r       = out_valid && !out_ready;
        prev_out      = out;
        @(posedge clk);
        @(negedge clk);
        cycle++;
    endtask

    task automatic drain(int budget);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        logic [27:0] bx[5];
        logic [27:0] by[5];
        logic [27:0] bexp[5];
        logic [27:0] bpx[8];
        logic [27:0] bpy[8];
        int idx;
        int c;
        int n;
        int cyc;

        n_tests = 0; n_fail = 0; cycle = 0;
        first_in = -1; first_out = -1; last_out = -1;
        stall_r = 1'b0; prev_out = 28'd0;
        rst_n = 1'b0; q = Q_12289; in_valid = 1'b0; x = 28'd0; y = 28'd0; out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out", out, 28'd0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);

        // Basic sequence
        bx = '{28'd10, 28'd5, 28'd7, 28'd0, 28'd12288};
        by = '{28'd5, 28'd10, 28'd7, 28'd12288, 28'd0};
        bexp = '{28'd5, 28'd12284, 28'd0, 28'd1, 28'd12288};
        got_q.delete(); first_in = -1; first_out = -1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; x = bx[i]; y = by[i];
            tick();
        end
        drain(20);
        check("basic_latency", first_out - first_in, 2);
        check("basic_rate", last_out - first_out, 4);
        check("basic_count", got_q.size(), 5);
        if (got_q.size() == 5) begin
            for (int i = 0; i < 5; i++) check("basic_value", got_q[i], bexp[i]);
        end

        // Backpressure: out_ready low on cycles 3..7
        bpx[0] = 28'd10; bpy[0] = 28'd5;
        for (int i = 1; i < 8; i++) begin
            bpx[i] = 28'($urandom % 12289);
            bpy[i] = 28'($urandom % 12289);
        end
        got_q.delete(); idx = 0; c = 1;
        while ((idx < 8 || exp_q.size() != 0) && c < 40) begin
            in_valid  = (idx < 8);
            x         = (idx < 8) ? bpx[idx] : 28'd0;
            y         = (idx < 8) ? bpy[idx] : 28'd0;
            out_ready = !(c >= 3 && c <= 7);
            if (c >= 3 && c <= 7) check("bp_hold5", out, 28'd5);
            tick();
            if (c == 3) check("bp_ready_low", last_in_ready, 1'b0);
            if (last_in_xfer) idx++;
            c++;
        end
        check("bp_sent", idx, 8);
        check("bp_count", got_q.size(), 8);
        if (got_q.size() != 0) check("bp_first", got_q[0], 28'd5);

        // Full pipe with simultaneous in/out transfers
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            x = 28'($urandom % 12289);
            y = 28'($urandom % 12289);
            tick();
            if (k >= 2) begin
                check("full_in", last_in_xfer, 1'b1);
                check("full_out", last_out_xfer, 1'b1);
                check("full_busy", busy, 1'b1);
            end
        end
        drain(20);

        // Wide modulus
        q = Q_28BIT; got_q.delete(); out_ready = 1'b1;
        in_valid = 1'b1; x = 28'd0; y = 28'd268369920; tick();
        x = 28'd268369920; y = 28'd1; tick();
        drain(20);
        check("wide_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("wide_0", got_q[0], 28'd1);
            check("wide_1", got_q[1], 28'd268369919);
        end

        // Reset mid-operation with both stages full
        q = Q_12289; out_ready = 1'b0; in_valid = 1'b1;
        x = 28'd100; y = 28'd200; tick();
        x = 28'd300; y = 28'd50;  tick();
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_out", out, 28'd0);
        exp_q.delete(); stall_r = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_stale", last_out_xfer, 1'b0);
        end
        got_q.delete(); first_in = -1; first_out = -1;
        in_valid = 1'b1; x = 28'd3; y = 28'd4; tick();
        in_valid = 1'b0; tick(); tick();
        check("midrst_latency", first_out - first_in, 2);
        check("midrst_count", got_q.size(), 1);
        if (got_q.size() != 0) check("midrst_value", got_q[0], 28'd12288);

        // Random soak over both moduli
        for (int phase = 0; phase < 2; phase++) begin
            q = (phase == 1) ? Q_28BIT : Q_12289;
            n = 0; cyc = 0;
            while (n < 5000 && cyc < 30000) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                x         = 28'($urandom % q);
                y         = 28'($urandom % q);
                out_ready = ($urandom_range(0, 3) != 0);
                tick();
                if (last_in_xfer) n++;
                cyc++;
            end
            drain(50);
            check("soak_count", n, 5000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mod_sub_pipe

// File: doc/mod_sub_pipe.md
Name: mod_sub_pipe

Overview:
- Pipelined modular subtractor: out = (x - y) mod q for operands already reduced into [0, q).
- Inverse counterpart of the combinational modular adder in the NTT butterfly datapath. Supplies the a - w*b leg of Cooley-Tukey / Gentleman-Sande butterflies.
- Two register stages with valid/ready flow control, so the pipeline can stall under downstream backpressure without dropping data.

Parameters:
- WIDTH, 28, operand/modulus width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- q  in  WIDTH  modulus. Held stable whenever busy=1.
- in_valid  in  1  input operands valid.
- in_ready  out  1  stage 1 can accept this cycle.
- x  in  WIDTH  minuend, 0 <= x < q.
- y  in  WIDTH  subtrahend, 0 <= y < q.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out  out  WIDTH  (x - y) mod q.
- busy  out  1  at least one stage holds valid data.

Behaviour:
- Reset (async assert, sync release): v1=v2=0, out_valid=0, out=0, busy=0. Internal data registers are cleared to 0. in_ready=1 in the cycle after release.
- Operations in flight when reset asserts are discarded. No output appears for them after release.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_valid must not depend combinationally on out_ready.
- Stage advance:
  - adv2 = !v2 || out_ready.
  - adv1 = !v1 || adv2.
  - in_ready = adv1. This is a combinational path from out_ready. No skid buffer is used.
- Stage 1, on adv1:
  - d1 <= {1'b0,x} - {1'b0,y}, a WIDTH+1-bit two's-complement difference.
  - b1 <= borrow, i.e. d1[WIDTH].
  - v1 <= in_valid.
- Stage 2, on adv2:
  - r2 <= b1 ? (d1[WIDTH-1:0] + q) mod 2^WIDTH : d1[WIDTH-1:0].
  - v2 <= v1.
- Outputs: out = r2, out_valid = v2.
- Registers hold their value when the stage does not advance.
- Latency: exactly 2 cycles from input transfer to out_valid when out_ready stays 1.
- Throughput: 1 result per cycle.
- Ordering: results are strictly in input order. No reordering and no loss.
- Stall:
  - out_ready=0 with v2=1 freezes stage 2.
  - Stage 1 still accepts one more operand if v1=0, then in_ready drops.
- Simultaneous events: an output transfer and an input transfer in the same cycle are legal when both stages are full, and the pipe remains full.
- busy = v1 || v2.
- Boundary cases:
  - x=y gives 0.
  - x=0, y=q-1 gives 1.
  - x=q-1, y=0 gives q-1.
  - If x or y >= q, the output follows the arithmetic formula above but is not guaranteed to be reduced. Verification only checks in-range operands.
- When out_valid=0, out holds its last value; it is not zeroed.

Decomposition:
- Shared package ntt_pkg holds:
  - WIDTH default (28).
  - Word typedef for a WIDTH-bit coefficient.
  - Test moduli constants Q_12289 and Q_28BIT = 268369921.
- One natural sub-module: mod_sub_core. It is the combinational borrow-correct step, used by stage 2 and reusable by the butterfly unit.
- Flow control stays in the top module.

Test Plan:
- Basic: q=12289, out_ready=1, inputs (x,y) = (10,5), (5,10), (7,7), (0,12288), (12288,0) on consecutive cycles. Required outputs: 5, 12284, 0, 1, 12288, in order, first out_valid exactly 2 cycles after the first transfer, one result per cycle.
- Backpressure: stream 8 operands with out_ready=0 for cycles 3-7.
  - in_ready falls once both stages are full.
  - out holds 5 stably during the stall.
  - No drops or duplicates; all 8 results arrive in order once out_ready=1.
- Full pipe, simultaneous transfer: both stages valid, in_valid=1, out_ready=1. Required: one in and one out per cycle, busy stays 1, in_ready stays 1.
- Wide modulus: q=268369921, x=0, y=268369920 gives 1; x=268369920, y=1 gives 268369919. No overflow in the WIDTH+1-bit difference.
- Reset mid-operation: assert rst_n=0 with v1=v2=1 for 1 cycle, then release.
  - out_valid=0 and busy=0 immediately on assertion.
  - No stale results after release.
  - Next input (3,4) with q=12289 gives 12288 after 2 cycles.
- Random soak: 10k random in-range operands with random in_valid and out_ready, checked against a reference model of (x - y + q) % q, with a scoreboard confirming order.
